// File: rtl/rv32i_pkg.sv
// rv32i_pkg
//   Shared RV32I decode definitions: major opcode constants, the instruction
//   format encoding used on decode_stage.out_fmt, and helpers that map an
//   opcode to its format and build the sign-extended 32-bit immediate.
//   No ports; imported by decode_stage.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // Every legal opcode ends in 2'b11, so a compressed/garbage low pair
    // never matches a case item and lands on FMT_ILL.
    function automatic fmt_e opcode_to_fmt(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OPC_OP:                                   fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM, OPC_MISC_MEM:                 fmt = FMT_I;
            OPC_STORE:                                fmt = FMT_S;
            OPC_BRANCH:                               fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                       fmt = FMT_U;
            OPC_JAL:                                  fmt = FMT_J;
            default:                                  fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

    function automatic logic [31:0] imm_gen(input fmt_e fmt, input logic [31:0] ir);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
            FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U:   imm = {ir[31:12], 12'b0};
            FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// decode_stage_regfile
//   Integer register file: NREGS x XLEN, two combinational read ports and
//   one synchronous write port. Synchronous reset clears every entry in one
//   cycle. x0 is never written and always reads 0.
// Ports
//   clk, rst            clock, synchronous active-high clear
//   we, waddr, wdata    write port (ignored for waddr == 0)
//   raddr1/2, rdata1/2  read ports
module decode_stage_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Registered RV32I decode stage between fetch and execute. Accepts an
//   instruction + PC, produces register operands, immediate, field slices,
//   format and illegal flag one cycle later. Owns the integer register file
//   and forwards same-cycle writeback into the operands.
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_ir/in_pc  upstream handshake + payload
//   flush                          kill held/incoming instruction
//   wb_we/wb_addr/wb_data          regfile writeback
//   out_valid/out_ready            downstream handshake
//   out_pc, out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd,
//   out_imm, out_opcode, out_funct3, out_funct7, out_fmt, out_illegal
//                                  decoded bundle
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and payload stable until it transfers;
// in_ready depends only on out_valid and out_ready, never on in_valid.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    // Pipeline register
    logic            valid_q,   valid_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;
    logic [AW-1:0]   rs1_q,     rs1_d;
    logic [AW-1:0]   rs2_q,     rs2_d;
    logic [AW-1:0]   rd_q,      rd_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    logic [6:0]      opcode_q,  opcode_d;
    logic [2:0]      funct3_q,  funct3_d;
    logic [6:0]      funct7_q,  funct7_d;
    logic [2:0]      fmt_q,     fmt_d;
    logic            illegal_q, illegal_d;

    // Combinational decode of the incoming word
    fmt_e            dec_fmt;
    logic [31:0]     dec_imm32;
    logic [AW-1:0]   dec_rs1, dec_rs2, dec_rd;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            load, stall;
    logic            byp1, byp2;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;
    assign stall    = valid_q && !out_ready;

    assign dec_fmt   = opcode_to_fmt(in_ir[6:0]);
    assign dec_imm32 = imm_gen(dec_fmt, in_ir);
    assign dec_rs1   = in_ir[15 +: AW];
    assign dec_rs2   = in_ir[20 +: AW];
    assign dec_rd    = in_ir[7 +: AW];

    decode_stage_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (dec_rs1),
        .raddr2 (dec_rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // The regfile write lands on the same edge as the load, so without the
    // bypass the operand would capture the pre-write value.
    assign byp1 = (BYPASS_EN != 0) && wb_we && (wb_addr == dec_rs1) && (dec_rs1 != '0);
    assign byp2 = (BYPASS_EN != 0) && wb_we && (wb_addr == dec_rs2) && (dec_rs2 != '0);

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        fmt_d     = fmt_q;
        illegal_d = illegal_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (load && !flush) begin
            pc_d      = in_pc;
            rs1_val_d = byp1 ? wb_data : rf_rdata1;
            rs2_val_d = byp2 ? wb_data : rf_rdata2;
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            rd_d      = dec_rd;
            imm_d     = XLEN'($signed(dec_imm32));
            opcode_d  = in_ir[6:0];
            funct3_d  = in_ir[14:12];
            funct7_d  = in_ir[31:25];
            fmt_d     = dec_fmt;
            illegal_d = (dec_fmt == FMT_ILL) || (in_ir[1:0] != 2'b11);
        end else if (stall) begin
            // Keep held operands coherent with writebacks that retire while
            // execute is not accepting.
            if (wb_we && (wb_addr == rs1_q) && (rs1_q != '0)) rs1_val_d = wb_data;
            if (wb_we && (wb_addr == rs2_q) && (rs2_q != '0)) rs2_val_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            fmt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            fmt_q     <= fmt_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_rs1_val = rs1_val_q;
    assign out_rs2_val = rs2_val_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd      = rd_q;
    assign out_imm     = imm_q;
    assign out_opcode  = opcode_q;
    assign out_funct3  = funct3_q;
    assign out_funct7  = funct7_q;
    assign out_fmt     = fmt_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ir;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [AW-1:0]   out_rs1;
    logic [AW-1:0]   out_rs2;
    logic [AW-1:0]   out_rd;
    logic [XLEN-1:0] out_imm;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ir       (in_ir),
        .in_pc       (in_pc),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_imm     (out_imm),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drivers
    task automatic issue(input logic [31:0] ir, input logic [XLEN-1:0] pc);
        in_valid = 1'b1;
        in_ir    = ir;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
        wb_we   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_we   = 1'b0;
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        // Fill every register so the later clear is observable.
        for (int i = 1; i < 32; i++) wb_write(AW'(i), 32'hA5A5_0000 + i);
        // Writeback coinciding with reset must lose.
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE_F00D;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wb_we = 1'b0;

        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++;
        if (out_pc !== '0 || out_imm !== '0 || out_fmt !== 3'd0 || out_opcode !== 7'd0)
        begin errors++; $display("FAIL reset_outs: pc %h imm %h fmt %0d opc %h expected all 0", out_pc, out_imm, out_fmt, out_opcode); end

        out_ready = 1'b1;
        for (int i = 1; i < 32; i++) begin
            issue(r_add(5'd0, 5'(i), 5'(i)), 32'h1000 + 4 * i);
            checks++;
            if (out_valid !== 1'b1 || out_rs1 !== AW'(i) || out_rs1_val !== '0 || out_rs2_val !== '0) begin
                errors++;
                $display("FAIL reset_regfile x%0d: valid %0b rs1 %0d vals %h %h expected 1 %0d 0 0",
                         i, out_valid, out_rs1, out_rs1_val, out_rs2_val, i);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0b expected 0", out_valid); end
    endtask

    task automatic test_imm();
        out_ready = 1'b1;
        issue(32'hFFF0_0093, 32'h0000_0100);  // addi x1,x0,-1
        checks++;
        if (out_valid !== 1'b1 || out_fmt !== 3'd1 || out_rd !== 5'd1 || out_imm !== 32'hFFFF_FFFF ||
            out_opcode !== 7'h13 || out_illegal !== 1'b0 || out_pc !== 32'h100)
        begin errors++; $display("FAIL addi: valid %0b fmt %0d rd %0d imm %h opc %h ill %0b pc %h expected 1 1 1 ffffffff 13 0 100",
                                  out_valid, out_fmt, out_rd, out_imm, out_opcode, out_illegal, out_pc); end

        issue(32'h0020_A423, 32'h0000_0104);  // sw x2,8(x1)
        checks++;
        if (out_fmt !== 3'd2 || out_imm !== 32'h0000_0008 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_funct3 !== 3'd2)
        begin errors++; $display("FAIL sw: fmt %0d imm %h rs1 %0d rs2 %0d f3 %0d expected 2 00000008 1 2 2",
                                  out_fmt, out_imm, out_rs1, out_rs2, out_funct3); end

        issue(32'hFE00_0EE3, 32'h0000_0108);  // beq x0,x0,-4
        checks++;
        if (out_fmt !== 3'd3 || out_imm !== 32'hFFFF_FFFC || out_funct7 !== 7'h7F)
        begin errors++; $display("FAIL beq: fmt %0d imm %h f7 %h expected 3 fffffffc 7f", out_fmt, out_imm, out_funct7); end

        issue(32'h1234_5037, 32'h0000_010C);  // lui x0,0x12345
        checks++;
        if (out_fmt !== 3'd4 || out_imm !== 32'h1234_5000)
        begin errors++; $display("FAIL lui: fmt %0d imm %h expected 4 12345000", out_fmt, out_imm); end

        issue(32'h0080_00EF, 32'h0000_0110);  // jal x1,8
        checks++;
        if (out_fmt !== 3'd5 || out_imm !== 32'h0000_0008 || out_rd !== 5'd1)
        begin errors++; $display("FAIL jal: fmt %0d imm %h rd %0d expected 5 00000008 1", out_fmt, out_imm, out_rd); end

        issue(32'h4000_0033, 32'h0000_0114);  // sub x0,x0,x0
        checks++;
        if (out_fmt !== 3'd0 || out_imm !== '0 || out_funct7 !== 7'h20)
        begin errors++; $display("FAIL sub: fmt %0d imm %h f7 %h expected 0 0 20", out_fmt, out_imm, out_funct7); end
        tick();
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        wb_write(5'd5, 32'h1111_1111);
        issue(32'h0052_8333, 32'h200);  // add x6,x5,x5, plain read
        checks++;
        if (out_rs1_val !== 32'h1111_1111 || out_rs2_val !== 32'h1111_1111 || out_rd !== 5'd6)
        begin errors++; $display("FAIL plain_read: %h %h rd %0d expected 11111111 11111111 6", out_rs1_val, out_rs2_val, out_rd); end

        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        issue(32'h0052_8333, 32'h204);
        wb_we = 1'b0;
        checks++;
        if (out_rs1_val !== 32'hDEAD_BEEF || out_rs2_val !== 32'hDEAD_BEEF)
        begin errors++; $display("FAIL bypass: %h %h expected deadbeef deadbeef", out_rs1_val, out_rs2_val); end

        issue(32'h0052_8333, 32'h208);
        checks++;
        if (out_rs1_val !== 32'hDEAD_BEEF || out_rs2_val !== 32'hDEAD_BEEF)
        begin errors++; $display("FAIL post_wb_read: %h %h expected deadbeef deadbeef", out_rs1_val, out_rs2_val); end
        tick();
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b0;
        issue(32'h0052_8333, 32'h300);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rs1_val !== 32'hDEAD_BEEF)
        begin errors++; $display("FAIL stall_load: valid %0b in_ready %0b rs1v %h expected 1 0 deadbeef", out_valid, in_ready, out_rs1_val); end

        // Writeback while held, with a competing input that must not enter.
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        issue(32'hFFF0_0093, 32'h304);
        wb_we = 1'b0;
        checks++;
        if (out_rs1_val !== 32'h1234 || out_rs2_val !== 32'h1234)
        begin errors++; $display("FAIL stall_refresh: %h %h expected 00001234 00001234", out_rs1_val, out_rs2_val); end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_pc !== 32'h300 || out_rd !== 5'd6)
        begin errors++; $display("FAIL stall_hold: valid %0b in_ready %0b pc %h rd %0d expected 1 0 300 6", out_valid, in_ready, out_pc, out_rd); end

        // Writeback to an unrelated register leaves held operands alone.
        wb_write(5'd9, 32'h9999_9999);
        checks++;
        if (out_rs1_val !== 32'h1234 || out_rs2_val !== 32'h1234)
        begin errors++; $display("FAIL stall_unrelated_wb: %h %h expected 00001234 00001234", out_rs1_val, out_rs2_val); end

        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin errors++; $display("FAIL flush_held: valid %0b in_ready %0b expected 0 1", out_valid, in_ready); end

        // Flush beats a simultaneous handshake.
        flush = 1'b1;
        issue(32'hFFF0_0093, 32'h308);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0)
        begin errors++; $display("FAIL flush_incoming: valid %0b expected 0", out_valid); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_x0_illegal();
        out_ready = 1'b1;
        wb_write(5'd0, 32'hFFFF_FFFF);
        issue(32'h0000_00B3, 32'h400);  // add x1,x0,x0
        checks++;
        if (out_rs1_val !== '0 || out_rs2_val !== '0)
        begin errors++; $display("FAIL x0_read: %h %h expected 0 0", out_rs1_val, out_rs2_val); end

        // x0 writeback in the load cycle must not be forwarded.
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        issue(32'h0000_00B3, 32'h404);
        wb_we = 1'b0;
        checks++;
        if (out_rs1_val !== '0 || out_rs2_val !== '0)
        begin errors++; $display("FAIL x0_bypass: %h %h expected 0 0", out_rs1_val, out_rs2_val); end

        issue(32'h0000_0000, 32'h408);
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_fmt !== 3'd7 || out_imm !== '0)
        begin errors++; $display("FAIL illegal_zero: valid %0b ill %0b fmt %0d imm %h expected 1 1 7 0", out_valid, out_illegal, out_fmt, out_imm); end

        issue(32'hFFF0_0090, 32'h40C);  // addi with low bits 00
        checks++;
        if (out_illegal !== 1'b1 || out_fmt !== 3'd7 || out_imm !== '0)
        begin errors++; $display("FAIL illegal_low_bits: ill %0b fmt %0d imm %h expected 1 7 0", out_illegal, out_fmt, out_imm); end

        issue(32'h0000_0073, 32'h410);  // ecall -> SYSTEM, I-format
        checks++;
        if (out_illegal !== 1'b0 || out_fmt !== 3'd1)
        begin errors++; $display("FAIL system: ill %0b fmt %0d expected 0 1", out_illegal, out_fmt); end

        out_ready = 1'b0;
        issue(32'h0000_00B3, 32'h414);
        checks++;
        if (out_valid !== 1'b1)
        begin errors++; $display("FAIL pre_reset_stall: valid %0b expected 1", out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== '0 || in_ready !== 1'b1)
        begin errors++; $display("FAIL reset_mid_stall: valid %0b pc %h in_ready %0b expected 0 0 1", out_valid, out_pc, in_ready); end

        // Register contents cleared by that reset too.
        out_ready = 1'b1;
        issue(32'h0052_8333, 32'h418);
        checks++;
        if (out_rs1_val !== '0 || out_rs2_val !== '0)
        begin errors++; $display("FAIL regfile_after_reset: %h %h expected 0 0", out_rs1_val, out_rs2_val); end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ir     = '0;
        in_pc     = '0;
        flush     = 1'b0;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        out_ready = 1'b0;

        test_reset();
        test_imm();
        test_bypass();
        test_stall_flush();
        test_x0_illegal();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
